// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN pixel width, map sizes and pixel helpers
package cnn_pkg;
  localparam int DATA_W = 9;
  localparam int IN_W = 28;
  localparam int KERNEL = 5;
  localparam int IMG_W = IN_W - KERNEL + 1;
  localparam int IMG_H = IMG_W;
  typedef logic signed [DATA_W-1:0] pix_t;
  function automatic pix_t signed_max(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction
  function automatic pix_t relu(input pix_t a);
    return a[DATA_W-1] ? '0 : a;
  endfunction
endpackage

// File: rtl/maxpool_2x2_if.sv
// maxpool_2x2_if: conv-to-pool raster stream bundle
interface maxpool_2x2_if #(parameter int DATA_W = cnn_pkg::DATA_W);
  logic conv_valid;
  logic signed [DATA_W-1:0] conv_data;
  logic pool_valid;
  logic signed [DATA_W-1:0] pool_data;
  logic frame_done;
  modport master (output conv_valid, conv_data, input pool_valid, pool_data, frame_done);
  modport slave (input conv_valid, conv_data, output pool_valid, pool_data, frame_done);
endinterface

// File: rtl/pool_line_buf.sv
// pool_line_buf: one row of horizontal maxima, sync write / async read
module pool_line_buf #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DEPTH = cnn_pkg::IMG_W / 2,
  parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);
  logic signed [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: 2x2 stride-2 max pooling over a raster stream, optional ReLU
module maxpool_2x2 import cnn_pkg::*; #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W = cnn_pkg::IMG_W,
  parameter int IMG_H = cnn_pkg::IMG_H,
  parameter int RELU = 1
) (
  input logic clk,
  input logic rstn,
  maxpool_2x2_if.slave s
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int AW = CW > 1 ? CW - 1 : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_PEN = CW'(IMG_W - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_PEN = RW'(IMG_H - 2);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic signed [DATA_W-1:0] h_q, h_d, pool_data_q, pool_data_d, hmax, win_max, lb_rd;
  logic pool_valid_q, pool_valid_d, frame_done_q, frame_done_d, lb_we, fire;
  logic [AW-1:0] lb_addr;
  // even rows park their horizontal max; odd rows fold it into the window
  always_comb begin
    lb_addr = AW'(col_q >> 1);
    hmax = signed_max(h_q, s.conv_data);
    win_max = signed_max(lb_rd, hmax);
    fire = s.conv_valid && col_q[0] && row_q[0];
    lb_we = s.conv_valid && col_q[0] && !row_q[0];
    pool_valid_d = fire;
    pool_data_d = fire ? (RELU != 0 ? relu(win_max) : win_max) : pool_data_q;
    frame_done_d = fire && col_q >= COL_PEN && row_q >= ROW_PEN;
    h_d = (s.conv_valid && !col_q[0]) ? s.conv_data : h_q;
    col_d = !s.conv_valid ? col_q : (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    row_d = !(s.conv_valid && col_q == COL_LAST) ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
      h_q <= '0;
      pool_valid_q <= 1'b0;
      pool_data_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      h_q <= h_d;
      pool_valid_q <= pool_valid_d;
      pool_data_q <= pool_data_d;
      frame_done_q <= frame_done_d;
    end
  end
  pool_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W / 2), .AW(AW)) u_lb (
    .clk(clk),
    .we(lb_we),
    .waddr(lb_addr),
    .wdata(hmax),
    .raddr(lb_addr),
    .rdata(lb_rd)
  );
  assign s.pool_valid = pool_valid_q;
  assign s.pool_data = pool_data_q;
  assign s.frame_done = frame_done_q;
endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: directed and random frames against a 2x2 window golden model
module tb_maxpool_2x2;
  localparam int DW = 9;
  localparam int SW = 4;
  localparam int BW = 24;
  typedef logic signed [DW-1:0] pix_t;
  typedef struct { pix_t d; logic done; int cyc; } exp_t;
  logic clk = 0;
  logic rstn = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  int n_c = 0, fd_c = 0, n0, f0;
  int rs = 0, cs = 0, rb = 0, cb = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  exp_t ea, eb, ec;
  pix_t frm_s[SW][SW];
  pix_t frm_b[BW][BW];
  pix_t t1[4] = '{-3, -8, -1, -5};
  pix_t t2[4] = '{-256, 255, 0, 1};
  maxpool_2x2_if #(.DATA_W(DW)) ia ();
  maxpool_2x2_if #(.DATA_W(DW)) ib ();
  maxpool_2x2_if #(.DATA_W(DW)) ic ();
  maxpool_2x2 #(.DATA_W(DW), .IMG_W(SW), .IMG_H(SW), .RELU(1)) u_a (.clk(clk), .rstn(rstn), .s(ia));
  maxpool_2x2 #(.DATA_W(DW), .IMG_W(SW), .IMG_H(SW), .RELU(0)) u_b (.clk(clk), .rstn(rstn), .s(ib));
  maxpool_2x2 #(.DATA_W(DW), .IMG_W(BW), .IMG_H(BW), .RELU(1)) u_c (.clk(clk), .rstn(rstn), .s(ic));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t mx(input pix_t a, input pix_t b);
    return a > b ? a : b;
  endfunction

  function automatic pix_t rl(input pix_t a);
    return a < 0 ? pix_t'(0) : a;
  endfunction

  function automatic pix_t pat(input int sel, input int r, input int c);
    int i;
    i = (r % 2) * 2 + c % 2;
    if (sel == 0) return pix_t'(r * 4 + c);
    if (sel == 1) return t1[i];
    if (r < 2 && c < 2) return t2[i];
    if (r < 2) return pix_t'(-256);
    return pix_t'(r * 4 + c - 16);
  endfunction

  task automatic beat_s(input logic v, input pix_t d);
    pix_t m;
    @(posedge clk); #1;
    ia.conv_valid = v; ia.conv_data = d;
    ib.conv_valid = v; ib.conv_data = d;
    if (v) begin
      frm_s[rs][cs] = d;
      if (rs % 2 == 1 && cs % 2 == 1) begin
        m = mx(mx(frm_s[rs-1][cs-1], frm_s[rs-1][cs]), mx(frm_s[rs][cs-1], d));
        q_a.push_back('{rl(m), logic'(rs == SW - 1 && cs == SW - 1), cyc});
        q_b.push_back('{m, logic'(rs == SW - 1 && cs == SW - 1), cyc});
      end
      cs = cs + 1;
      if (cs == SW) begin cs = 0; rs = (rs == SW - 1) ? 0 : rs + 1; end
    end
  endtask

  task automatic beat_b(input logic v, input pix_t d);
    pix_t m;
    @(posedge clk); #1;
    ic.conv_valid = v; ic.conv_data = d;
    if (v) begin
      frm_b[rb][cb] = d;
      if (rb % 2 == 1 && cb % 2 == 1) begin
        m = mx(mx(frm_b[rb-1][cb-1], frm_b[rb-1][cb]), mx(frm_b[rb][cb-1], d));
        q_c.push_back('{rl(m), logic'(rb == BW - 1 && cb == BW - 1), cyc});
      end
      cb = cb + 1;
      if (cb == BW) begin cb = 0; rb = (rb == BW - 1) ? 0 : rb + 1; end
    end
  endtask

  always @(negedge clk) if (rstn) begin
    if (ia.pool_valid) begin
      if (q_a.size() == 0) chk("a_unexpected", ia.pool_valid, 0);
      else begin
        ea = q_a.pop_front();
        chk("a_data", ia.pool_data, ea.d);
        chk("a_done", ia.frame_done, ea.done);
        chk("a_latency", cyc, ea.cyc + 1);
      end
    end else chk("a_fd_idle", ia.frame_done, 0);
  end

  always @(negedge clk) if (rstn) begin
    if (ib.pool_valid) begin
      if (q_b.size() == 0) chk("b_unexpected", ib.pool_valid, 0);
      else begin
        eb = q_b.pop_front();
        chk("b_data", ib.pool_data, eb.d);
        chk("b_done", ib.frame_done, eb.done);
        chk("b_latency", cyc, eb.cyc + 1);
      end
    end else chk("b_fd_idle", ib.frame_done, 0);
  end

  always @(negedge clk) if (rstn) begin
    if (ic.pool_valid) begin
      n_c++;
      fd_c += int'(ic.frame_done);
      if (q_c.size() == 0) chk("c_unexpected", ic.pool_valid, 0);
      else begin
        ec = q_c.pop_front();
        chk("c_data", ic.pool_data, ec.d);
        chk("c_done", ic.frame_done, ec.done);
        chk("c_latency", cyc, ec.cyc + 1);
      end
    end else chk("c_fd_idle", ic.frame_done, 0);
  end

  initial begin
    ia.conv_valid = 0; ia.conv_data = '0;
    ib.conv_valid = 0; ib.conv_data = '0;
    ic.conv_valid = 0; ic.conv_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", ia.pool_valid, 0);
    chk("rst_a_data", ia.pool_data, 0);
    chk("rst_a_done", ia.frame_done, 0);
    chk("rst_c_valid", ic.pool_valid, 0);
    chk("rst_c_data", ic.pool_data, 0);
    chk("rst_c_done", ic.frame_done, 0);
    rstn = 1;
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < SW; r++)
        for (int c = 0; c < SW; c++) beat_s(1, pat(f, r, c));
    beat_s(0, '0);
    beat_s(0, '0);
    chk("small_a_left", q_a.size(), 0);
    chk("small_b_left", q_b.size(), 0);
    n0 = n_c;
    for (int i = 0; i < BW * BW; i++) begin
      repeat ($urandom_range(0, 2)) beat_b(0, pix_t'($urandom));
      beat_b(1, pix_t'($urandom));
    end
    beat_b(0, '0);
    beat_b(0, '0);
    chk("gap_count", n_c - n0, 144);
    chk("gap_left", q_c.size(), 0);
    n0 = n_c;
    f0 = fd_c;
    for (int i = 0; i < 2 * BW * BW; i++) beat_b(1, pix_t'($urandom));
    beat_b(0, '0);
    beat_b(0, '0);
    chk("b2b_count", n_c - n0, 288);
    chk("b2b_frame_done", fd_c - f0, 2);
    chk("b2b_left", q_c.size(), 0);
    for (int i = 0; i < 7 * BW + 10; i++) beat_b(1, pix_t'($urandom));
    beat_b(0, '0);
    @(posedge clk); #1;
    rstn = 0;
    rb = 0;
    cb = 0;
    #3;
    chk("midrst_valid", ic.pool_valid, 0);
    chk("midrst_data", ic.pool_data, 0);
    chk("midrst_done", ic.frame_done, 0);
    chk("midrst_left", q_c.size(), 0);
    @(posedge clk); #1;
    rstn = 1;
    n0 = n_c;
    for (int i = 0; i < BW * BW; i++) beat_b(1, pix_t'($urandom));
    beat_b(0, '0);
    beat_b(0, '0);
    chk("post_rst_count", n_c - n0, 144);
    chk("post_rst_left", q_c.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
